umi_resp_fifo: RTL

//   Synchronous FIFO for whole UMI packets (cmd/dstaddr/srcaddr/data).

---
 rtl/umi_resp_fifo.sv | 99 +++++++++
 1 files changed

// File: rtl/umi_resp_fifo.sv
// Whole-packet FIFO between the umiram response port and umi_tx_sim; first-word fall-through, one edge push-to-visible.
// in_ready drops only when all DEPTH entries are occupied and rises the cycle after a pop; out_* hold until popped.
module umi_resp_fifo #(
    parameter int DW    = 256,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW-1:0]            in_cmd,
    input  logic [AW-1:0]            in_dstaddr,
    input  logic [AW-1:0]            in_srcaddr,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_cmd,
    output logic [AW-1:0]            out_dstaddr,
    output logic [AW-1:0]            out_srcaddr,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("umi_resp_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dstaddr;
        logic [AW-1:0] srcaddr;
        logic [DW-1:0] data;
    } pkt_t;

    pkt_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            push, pop;
    pkt_t            head;

    // Flow control is purely a function of registered occupancy.
    assign in_ready  = (count_q != CNTW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is never cleared; out_* are meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= '{cmd: in_cmd, dstaddr: in_dstaddr,
                                 srcaddr: in_srcaddr, data: in_data};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_cmd     = head.cmd;
    assign out_dstaddr = head.dstaddr;
    assign out_srcaddr = head.srcaddr;
    assign out_data    = head.data;
    assign count       = count_q;

endmodule
